// File: rtl/sparc_mem_pkg.sv
// ============================================================================
//  Module      : sparc_mem_pkg
//  Description : Shared definitions for the SPARC memory stage: op3 codes,
//                controller state encoding and the access-size decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sparc_mem_pkg;

  // SPARC op3 codes handled by the memory stage
  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_STD  = 6'b000111;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;

  // Controller states, explicitly encoded
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACCESS     = 2'd1,
    BEAT2_WAIT = 2'd2
  } state_e;

  // Decoded access shape; nbytes == 0 marks an unknown opcode
  typedef struct packed {
    logic [3:0] nbytes;
    logic       is_signed;
    logic       is_store;
  } size_info_t;

  // Opcode -> byte count, sign-extension flag and direction
  function automatic size_info_t size_decode(input logic [5:0] op);
    size_info_t info;
    info = '{nbytes: 4'd0, is_signed: 1'b0, is_store: 1'b0};
    case (op)
      OP_LD:   info = '{nbytes: 4'd4, is_signed: 1'b0, is_store: 1'b0};
      OP_LDUB: info = '{nbytes: 4'd1, is_signed: 1'b0, is_store: 1'b0};
      OP_LDUH: info = '{nbytes: 4'd2, is_signed: 1'b0, is_store: 1'b0};
      OP_LDSB: info = '{nbytes: 4'd1, is_signed: 1'b1, is_store: 1'b0};
      OP_LDSH: info = '{nbytes: 4'd2, is_signed: 1'b1, is_store: 1'b0};
      OP_LDD:  info = '{nbytes: 4'd8, is_signed: 1'b0, is_store: 1'b0};
      OP_ST:   info = '{nbytes: 4'd4, is_signed: 1'b0, is_store: 1'b1};
      OP_STB:  info = '{nbytes: 4'd1, is_signed: 1'b0, is_store: 1'b1};
      OP_STH:  info = '{nbytes: 4'd2, is_signed: 1'b0, is_store: 1'b1};
      OP_STD:  info = '{nbytes: 4'd8, is_signed: 1'b0, is_store: 1'b1};
      default: info = '{nbytes: 4'd0, is_signed: 1'b0, is_store: 1'b0};
    endcase
    return info;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_byte_array.sv
// ============================================================================
//  Module      : mem_byte_array
//  Description : Byte-addressed storage organised as four byte lanes. Lane i
//                holds the byte at word offset i; reads return the aligned
//                word big-endian (lane 0 in bits 31:24). Contents are never
//                reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_byte_array #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic [3:0]            wstrb,
  input  logic [ADDR_WIDTH-3:0] word_addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] bytes [DEPTH];

    // Write this lane's byte when its strobe is set
    always_ff @(posedge clk) begin
      if (wstrb[i]) bytes[word_addr] <= wdata[31-8*i -: 8];
    end

    assign rdata[31-8*i -: 8] = bytes[word_addr];
  end

endmodule

`default_nettype wire

// File: rtl/ram_access_controller.sv
// ============================================================================
//  Module      : ram_access_controller
//  Description : SPARC memory stage. Samples a RAM request, waits a fixed
//                number of states, then performs a big-endian byte/half/word/
//                doubleword access and pulses MFC with trap flags.
//                Optional feature macro: MEM_WRITE_PROTECT_EN (stores below
//                PROTECT_LIMIT are blocked and flagged with Prot_Trap).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_access_controller
  import sparc_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 9,
  parameter int          WAIT_STATES   = 2,
  parameter logic [31:0] PROTECT_LIMIT = 32'h0000_0040
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        RAM_enable,
  input  logic [5:0]  RAM_OpCode,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        Beat,
  output logic        Busy,
  output logic        Align_Trap,
  output logic        Prot_Trap
);

  localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

  state_e      state;
  logic        armed;
  logic        seen_low;
  logic        beat;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  cnt;

  size_info_t  info;
  logic [31:0] eff_addr;
  logic [1:0]  lane;
  logic        misaligned;
  logic        prot_hit;
  logic        commit_ok;
  logic        done;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;

  assign info     = size_decode(op_q);
  // Second doubleword beat targets the following word
  assign eff_addr = addr_q + (beat ? 32'd4 : 32'd0);
  assign lane     = eff_addr[1:0];
  assign done     = (state == ACCESS) && (cnt == 4'd0);
  assign Busy     = (state != IDLE);
  assign Beat     = beat;

  // Alignment is judged on the latched base address; beat 1 inherits it
  assign misaligned = ((info.nbytes == 4'd2) && addr_q[0]) ||
                      ((info.nbytes == 4'd4) && (addr_q[1:0] != 2'b00)) ||
                      ((info.nbytes == 4'd8) && (addr_q[2:0] != 3'b000));

`ifdef MEM_WRITE_PROTECT_EN
  assign prot_hit = info.is_store && (eff_addr < PROTECT_LIMIT);
`else
  logic unused_cfg;
  assign prot_hit   = 1'b0;
  assign unused_cfg = ^{eff_addr[31:ADDR_WIDTH], PROTECT_LIMIT};
`endif

  assign commit_ok = (info.nbytes != 4'd0) && !misaligned && !prot_hit;

  // Store lane strobes and lane-replicated write data
  always_comb begin
    wstrb = 4'b0000;
    wdata = data_q;
    case (info.nbytes)
      4'd1: begin
        wstrb = 4'b0001 << lane;
        wdata = {4{data_q[7:0]}};
      end
      4'd2: begin
        wstrb = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_q[15:0]}};
      end
      4'd4, 4'd8: wstrb = 4'b1111;
      default:    wstrb = 4'b0000;
    endcase
    if (!(done && commit_ok && info.is_store)) wstrb = 4'b0000;
  end

  mem_byte_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk       (Clk),
    .wstrb     (wstrb),
    .word_addr (eff_addr[ADDR_WIDTH-1:2]),
    .wdata     (wdata),
    .rdata     (rd_word)
  );

  // Big-endian lane select and zero/sign extension of load data
  always_comb begin
    rd_byte = 8'h00;
    case (lane)
      2'd0: rd_byte = rd_word[31:24];
      2'd1: rd_byte = rd_word[23:16];
      2'd2: rd_byte = rd_word[15:8];
      2'd3: rd_byte = rd_word[7:0];
      default: rd_byte = 8'h00;
    endcase
    rd_half  = lane[1] ? rd_word[15:0] : rd_word[31:16];
    load_val = rd_word;
    case (info.nbytes)
      4'd1: load_val = {{24{info.is_signed & rd_byte[7]}}, rd_byte};
      4'd2: load_val = {{16{info.is_signed & rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // Request sequencing, wait counting and result/flag registration
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      armed      <= 1'b1;
      seen_low   <= 1'b0;
      beat       <= 1'b0;
      op_q       <= 6'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      cnt        <= 4'd0;
      DataOut    <= 32'd0;
      MFC        <= 1'b0;
      Align_Trap <= 1'b0;
      Prot_Trap  <= 1'b0;
    end else begin
      MFC        <= 1'b0;
      Align_Trap <= 1'b0;
      Prot_Trap  <= 1'b0;
      case (state)
        IDLE: begin
          if (!RAM_enable) begin
            armed <= 1'b1;
          end else if (armed) begin
            op_q   <= RAM_OpCode;
            addr_q <= Address;
            data_q <= DataIn;
            cnt    <= C_WAIT;
            armed  <= 1'b0;
            beat   <= 1'b0;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            MFC        <= 1'b1;
            Align_Trap <= misaligned;
            Prot_Trap  <= !misaligned && prot_hit;
            if (commit_ok && !info.is_store) DataOut <= load_val;
            if (commit_ok && (info.nbytes == 4'd8) && !beat) begin
              seen_low <= 1'b0;
              state    <= BEAT2_WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        BEAT2_WAIT: begin
          if (!RAM_enable) begin
            seen_low <= 1'b1;
          end else if (seen_low) begin
            data_q <= DataIn;
            beat   <= 1'b1;
            cnt    <= C_WAIT;
            state  <= ACCESS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_access_controller.sv
// ============================================================================
//  Module      : tb_ram_access_controller
//  Description : Self-checking bench for ram_access_controller: directed
//                scenarios followed by randomized accesses compared against
//                a byte-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_access_controller;

  localparam int WS = 2;

  logic        Clk = 1'b0;
  logic        RESET = 1'b0;
  logic        RAM_enable = 1'b0;
  logic [5:0]  RAM_OpCode = 6'd0;
  logic [31:0] Address = 32'd0;
  logic [31:0] DataIn = 32'd0;
  logic [31:0] DataOut;
  logic        MFC, Beat, Busy, Align_Trap, Prot_Trap;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [512];
  logic [31:0] model_dout = 32'd0;

  ram_access_controller #(
    .ADDR_WIDTH    (9),
    .WAIT_STATES   (WS),
    .PROTECT_LIMIT (32'h0000_0040)
  ) dut (
    .Clk        (Clk),
    .RESET      (RESET),
    .RAM_enable (RAM_enable),
    .RAM_OpCode (RAM_OpCode),
    .Address    (Address),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .MFC        (MFC),
    .Beat       (Beat),
    .Busy       (Busy),
    .Align_Trap (Align_Trap),
    .Prot_Trap  (Prot_Trap)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: apply one beat of an access to the model, return expectations
  task automatic model_step(input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input int b,
                            output logic exp_al, output logic exp_pr, output logic more);
    int nb, width;
    logic sgn, store, mis, prot;
    logic [31:0] eff, val;
    nb = 0; sgn = 0; store = 0;
    case (op)
      6'd0:  nb = 4;
      6'd1:  nb = 1;
      6'd2:  nb = 2;
      6'd9:  begin nb = 1; sgn = 1; end
      6'd10: begin nb = 2; sgn = 1; end
      6'd3:  nb = 8;
      6'd4:  begin nb = 4; store = 1; end
      6'd5:  begin nb = 1; store = 1; end
      6'd6:  begin nb = 2; store = 1; end
      6'd7:  begin nb = 8; store = 1; end
      default: nb = 0;
    endcase
    eff  = addr + 32'(4 * b);
    mis  = (nb != 0) && ((addr % 32'(nb)) != 0);
    prot = 1'b0;
`ifdef MEM_WRITE_PROTECT_EN
    prot = store && (nb != 0) && !mis && (eff < 32'h40);
`endif
    width = (nb == 8) ? 4 : nb;
    if (nb != 0 && !mis && !prot) begin
      if (store) begin
        for (int i = 0; i < width; i++)
          model_mem[(eff + 32'(i)) % 512] = 8'(data >> (8 * (width - 1 - i)));
      end else begin
        val = 32'd0;
        for (int i = 0; i < width; i++)
          val = (val << 8) | 32'(model_mem[(eff + 32'(i)) % 512]);
        if (sgn && width == 1 && val[7])  val = val | 32'hFFFF_FF00;
        if (sgn && width == 2 && val[15]) val = val | 32'hFFFF_0000;
        model_dout = val;
      end
    end
    exp_al = mis;
    exp_pr = prot;
    more   = (nb == 8) && (b == 0) && !mis && !prot;
  endtask

  // Full access handshake; called at a negedge with RAM_enable low
  task automatic access(input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] d0, input logic [31:0] d1, input int hold);
    logic exp_al, exp_pr, more;
    int k, extra;
    bit got;
    RAM_OpCode = op; Address = addr; DataIn = d0; RAM_enable = 1'b1;
    for (int b = 0; b < 2; b++) begin
      model_step(op, addr, (b == 0) ? d0 : d1, b, exp_al, exp_pr, more);
      k = 0; got = 0;
      while (k < 40 && !got) begin
        @(negedge Clk);
        k++;
        if (MFC === 1'b1) got = 1;
      end
      if (!got) begin
        check("mfc_timeout", 32'd0, 32'd1);
        RAM_enable = 1'b0;
        @(negedge Clk);
        return;
      end
      check("latency", 32'(k), 32'(WS + 2));
      check("dataout", DataOut, model_dout);
      check("align_trap", 32'(Align_Trap), 32'(exp_al));
      check("prot_trap", 32'(Prot_Trap), 32'(exp_pr));
      check("beat", 32'(Beat), 32'(b));
      check("busy_at_mfc", 32'(Busy), 32'(more));
      if (!more && hold > 0) RAM_enable = 1'b1;
      else RAM_enable = 1'b0;
      @(negedge Clk);
      check("mfc_one_cycle", 32'(MFC), 32'd0);
      if (!more) break;
      DataIn = d1;
      RAM_enable = 1'b1;
    end
    if (hold > 0) begin
      extra = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge Clk);
        if (MFC === 1'b1) extra++;
      end
      check("held_enable_extra_mfc", 32'(extra), 32'd0);
      RAM_enable = 1'b0;
      @(negedge Clk);
    end
  endtask

  initial begin
    logic [5:0]  ops [11];
    logic [31:0] a;
    ops = '{6'd0, 6'd1, 6'd2, 6'd9, 6'd10, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'h2A};

    // Reset state
    #12;
    check("rst_dataout", DataOut, 32'd0);
    check("rst_flags", {26'd0, MFC, Beat, Busy, Align_Trap, Prot_Trap, 1'b0}, 32'd0);
    @(negedge Clk);
    RESET = 1'b1;
    @(negedge Clk);

    // Word store/load and sub-word extension
    access(6'd4, 32'h100, 32'hDEADBEEF, 32'd0, 0);
    access(6'd0, 32'h100, 32'd0, 32'd0, 0);
    check("ld_word", DataOut, 32'hDEADBEEF);
    access(6'd9, 32'h101, 32'd0, 32'd0, 0);
    check("ldsb", DataOut, 32'hFFFFFFAD);
    access(6'd1, 32'h101, 32'd0, 32'd0, 0);
    check("ldub", DataOut, 32'h000000AD);
    access(6'd2, 32'h102, 32'd0, 32'd0, 0);
    check("lduh", DataOut, 32'h0000BEEF);

    // Misaligned accesses
    access(6'd0, 32'h102, 32'd0, 32'd0, 0);
    access(6'd3, 32'h104, 32'd0, 32'd0, 0);
    check("align_dout_kept", DataOut, 32'h0000BEEF);

    // Doubleword store, then read back the odd word
    access(6'd7, 32'h108, 32'h11111111, 32'h22222222, 0);
    access(6'd0, 32'h10C, 32'd0, 32'd0, 0);
    check("std_odd_word", DataOut, 32'h22222222);

    // Held enable gives exactly one access
    access(6'd0, 32'h108, 32'd0, 32'd0, 20);

    // Reset in the middle of a store aborts it
    access(6'd4, 32'h110, 32'hCAFEF00D, 32'd0, 0);
    RAM_OpCode = 6'd4; Address = 32'h110; DataIn = 32'h12345678; RAM_enable = 1'b1;
    @(negedge Clk);
    check("busy_in_access", 32'(Busy), 32'd1);
    RESET = 1'b0;
    #1;
    check("midrst_dataout", DataOut, 32'd0);
    check("midrst_flags", {26'd0, MFC, Beat, Busy, Align_Trap, Prot_Trap, 1'b0}, 32'd0);
    RAM_enable = 1'b0;
    model_dout = 32'd0;
    @(negedge Clk);
    RESET = 1'b1;
    @(negedge Clk);
    access(6'd0, 32'h110, 32'd0, 32'd0, 0);
    check("abort_no_write", DataOut, 32'hCAFEF00D);

    // Store near the bottom of memory: 0x220 aliases 0x20 but is above the limit
    access(6'd4, 32'h220, 32'hAAAA5555, 32'd0, 0);
    access(6'd4, 32'h020, 32'h0BADF00D, 32'd0, 0);
    access(6'd0, 32'h220, 32'd0, 32'd0, 0);

    // Fill upper half so random loads read defined data
    for (int w = 32'h100; w < 32'h200; w += 4)
      access(6'd4, 32'(w), $urandom, 32'd0, 0);

    // Randomized mix
    for (int n = 0; n < 150; n++) begin
      a = 32'h100 + 32'($urandom_range(0, 32'hF7));
      if ($urandom_range(0, 3) != 0) a = a & ~32'h7 | (32'($urandom_range(0, 1)) << 2);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FE00);
      access(ops[$urandom_range(0, 10)], a, $urandom, $urandom, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
